dmem_io_arbiter: RTL and testbench
==================================

Name: dmem_io_arbiter

Overview:
Shares the data-memory/IO load-store path between two requesters: the CPU load/store unit (port C) and the UART program loader (port L). Sequences each access through a small FSM and decodes memory vs. IO by address. Drives the mRead/mWrite/ioRead/ioWrite strobes, address and write data that the memory-or-IO datapath consumes. Returns read data with a one-cycle ack pulse.

Parameters:
IO_BASE, 22'h3FFFFF, addr[31:10] value that selects IO space; any other value selects data memory.
IO_WAIT, 2, extra cycles an IO strobe is held beyond the first (0..15).

Ports:
clock  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
c_req  input  1  CPU request; held high until c_ack
c_we  input  1  CPU write (1) / read (0)
c_addr  input  32  CPU byte address
c_wdata  input  32  CPU store data
c_ack  output  1  one-cycle completion pulse to CPU
c_rdata  output  32  CPU load data, valid while c_ack=1
l_req  input  1  loader request
l_we  input  1  loader write/read
l_addr  input  32  loader address
l_wdata  input  32  loader store data
l_ack  output  1  one-cycle completion pulse to loader
l_rdata  output  32  loader load data, valid while l_ack=1
m_read  output  1  data-memory read strobe
m_write  output  1  data-memory write strobe
io_read  output  1  IO read strobe
io_write  output  1  IO write strobe
addr_out  output  32  latched access address
wdata_out  output  32  latched store data
m_rdata  input  32  data-memory read data, valid the cycle after m_read
io_rdata  input  24  IO read data, valid during the io_read strobe
busy  output  1  high in every state except IDLE
grant_id  output  1  0 = CPU owns the path, 1 = loader

Behaviour:
- Reset (async, rst_n=0): state IDLE; all strobes, acks, busy, grant_id = 0; addr_out, wdata_out, c_rdata, l_rdata = 0; last_grant = 1. Reset mid-access aborts immediately; no ack is issued for the aborted access.
- States: IDLE, MEM_STB, MEM_CAP, IO_STB, RESP.
- IDLE: if any req is high, pick a winner; latch addr, we, wdata and grant_id. Go to IO_STB if addr[31:10]==IO_BASE, else MEM_STB. Stay in IDLE with no request.
- MEM_STB (1 cycle): m_read=~we, m_write=we. Go to MEM_CAP.
- MEM_CAP (1 cycle): no strobes; latch m_rdata into the winner's rdata register on read. Go to RESP.
- IO_STB (IO_WAIT+1 cycles, down-counter): io_read=~we or io_write=we, held continuously. On the final cycle, a read latches {8'b0, io_rdata}. Go to RESP.
- RESP (1 cycle): pulse the winner's ack; rdata register is stable. Update last_grant=grant_id. Go to IDLE.
- Latency from req seen in IDLE (cycle N): memory ack in N+3; IO ack in N+3+IO_WAIT. Writes use identical timing. Rdata for a write is unchanged.
- The loser's req stays pending and is re-arbitrated in the IDLE after RESP; minimum spacing between grants is one IDLE cycle.
- A req still high in the cycle after ack is treated as a new access.
- A req dropped after grant is a protocol violation; the access still completes and ack still pulses.
- addr_out and wdata_out hold their value after an access until the next grant.
- Strobes are mutually exclusive and are never high in IDLE, MEM_CAP or RESP.

Optional Feature:
DMEM_IO_ARB_RR_EN
- Defined: round-robin. On simultaneous requests, the requester other than last_grant wins. After reset, last_grant=1, so the CPU wins the first tie.
- Undefined: fixed priority; the CPU always wins ties, and the loader is served only when c_req=0 in IDLE. last_grant is still maintained but ignored.

Decomposition:
- Package dmem_io_pkg: state enum (IDLE, MEM_STB, MEM_CAP, IO_STB, RESP), IO_BASE default, IO address-decode function, port-ID constants (PORT_CPU=0, PORT_LDR=1).
- Sub-module dmem_io_pick: combinational 2-way picker taking (c_req, l_req, last_grant) and returning grant_id. It holds the only macro-dependent logic.

Test Plan:
- CPU read 0x0000_0010, m_rdata=32'hDEADBEEF -> m_read high only in cycle N+1; c_ack pulse in N+3 with c_rdata=DEADBEEF; l_ack stays 0.
- Loader write 0xFFFF_FC60 data 0x00123456, IO_WAIT=2 -> io_write high for 3 cycles, addr_out=FFFFFC60, wdata_out=00123456; l_ack in N+5.
- CPU IO read 0xFFFF_FC70, io_rdata=24'hABCDEF -> c_rdata=32'h00ABCDEF.
- c_req and l_req both held high for 4 accesses -> with RR_EN, grants C,L,C,L; without RR_EN, grants C,C,C,C and l_ack never pulses.
- Assert rst_n=0 during IO_STB -> io_read/io_write drop asynchronously; no ack; after release, first tie goes to CPU.
- Loader request arrives while a CPU memory access is busy -> loader is granted in the IDLE after CPU RESP; its l_ack comes exactly 4 cycles after c_ack.

Source files
------------

// File: rtl/dmem_io_pkg.sv
// rtl/dmem_io_pkg.sv - shared types, IO decode and port IDs for the dmem/IO arbiter
package dmem_io_pkg;

  typedef enum logic [2:0] {IDLE, MEM_STB, MEM_CAP, IO_STB, RESP} state_t;

  localparam logic [21:0] IO_BASE_DEFAULT = 22'h3FFFFF;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  function automatic logic is_io_page(input logic [21:0] page, input logic [21:0] base);
    return page == base;
  endfunction

endpackage

// File: rtl/dmem_io_pick.sv
// rtl/dmem_io_pick.sv - 2-way requester picker; DMEM_IO_ARB_RR_EN selects round-robin
// over fixed CPU priority.
module dmem_io_pick
  import dmem_io_pkg::*;
(
  input  logic c_req,
  input  logic l_req,
  input  logic last_grant,
  output logic grant_id
);

`ifdef DMEM_IO_ARB_RR_EN
  always_comb begin
    grant_id = PORT_CPU;
    if (c_req && l_req)
      grant_id = ~last_grant;
    else if (l_req)
      grant_id = PORT_LDR;
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  assign grant_id = (!c_req && l_req) ? PORT_LDR : PORT_CPU;
`endif

endmodule

// File: rtl/dmem_io_arbiter.sv
// rtl/dmem_io_arbiter.sv - shares the data-memory/IO path between CPU and loader;
// tie policy set by DMEM_IO_ARB_RR_EN inside dmem_io_pick.
module dmem_io_arbiter
  import dmem_io_pkg::*;
#(
  parameter logic [21:0] IO_BASE = IO_BASE_DEFAULT,
  parameter int unsigned IO_WAIT = 2
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_ack,
  output logic [31:0] c_rdata,
  input  logic        l_req,
  input  logic        l_we,
  input  logic [31:0] l_addr,
  input  logic [31:0] l_wdata,
  output logic        l_ack,
  output logic [31:0] l_rdata,
  output logic        m_read,
  output logic        m_write,
  output logic        io_read,
  output logic        io_write,
  output logic [31:0] addr_out,
  output logic [31:0] wdata_out,
  input  logic [31:0] m_rdata,
  input  logic [23:0] io_rdata,
  output logic        busy,
  output logic        grant_id
);

  localparam logic [4:0] IO_CNT_INIT = 5'(IO_WAIT + 1);

  state_t      state, state_n;
  logic        pick_id;
  logic        we_q;
  logic        last_grant;
  logic [4:0]  io_cnt;
  logic        any_req;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_we;

  dmem_io_pick u_pick (
    .c_req      (c_req),
    .l_req      (l_req),
    .last_grant (last_grant),
    .grant_id   (pick_id)
  );

  assign any_req   = c_req | l_req;
  assign sel_addr  = (pick_id == PORT_LDR) ? l_addr  : c_addr;
  assign sel_wdata = (pick_id == PORT_LDR) ? l_wdata : c_wdata;
  assign sel_we    = (pick_id == PORT_LDR) ? l_we    : c_we;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_n;
  end

  // IO_STB keeps one strobe-free turnaround cycle once io_cnt reaches zero.
  always_comb begin
    state_n  = state;
    m_read   = 1'b0;
    m_write  = 1'b0;
    io_read  = 1'b0;
    io_write = 1'b0;
    case (state)
      IDLE: begin
        if (any_req)
          state_n = is_io_page(sel_addr[31:10], IO_BASE) ? IO_STB : MEM_STB;
      end
      MEM_STB: begin
        m_read  = ~we_q;
        m_write = we_q;
        state_n = MEM_CAP;
      end
      MEM_CAP: state_n = RESP;
      IO_STB: begin
        if (io_cnt != 5'd0) begin
          io_read  = ~we_q;
          io_write = we_q;
        end else begin
          state_n = RESP;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy  = (state != IDLE);
  assign c_ack = (state == RESP) && (grant_id == PORT_CPU);
  assign l_ack = (state == RESP) && (grant_id == PORT_LDR);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      addr_out   <= 32'd0;
      wdata_out  <= 32'd0;
      c_rdata    <= 32'd0;
      l_rdata    <= 32'd0;
      we_q       <= 1'b0;
      grant_id   <= PORT_CPU;
      last_grant <= PORT_LDR;
      io_cnt     <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            addr_out  <= sel_addr;
            wdata_out <= sel_wdata;
            we_q      <= sel_we;
            grant_id  <= pick_id;
            io_cnt    <= IO_CNT_INIT;
          end
        end
        MEM_CAP: begin
          if (!we_q) begin
            if (grant_id == PORT_LDR) l_rdata <= m_rdata;
            else                      c_rdata <= m_rdata;
          end
        end
        IO_STB: begin
          if (io_cnt != 5'd0) begin
            io_cnt <= io_cnt - 5'd1;
            if (io_cnt == 5'd1 && !we_q) begin
              if (grant_id == PORT_LDR) l_rdata <= {8'h00, io_rdata};
              else                      c_rdata <= {8'h00, io_rdata};
            end
          end
        end
        RESP:    last_grant <= grant_id;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_io_arbiter.sv
// tb/tb_dmem_io_arbiter.sv - scoreboard bench for dmem_io_arbiter
module tb_dmem_io_arbiter;

  localparam int IO_WAIT = 2;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        c_req = 1'b0, c_we = 1'b0;
  logic [31:0] c_addr = '0, c_wdata = '0;
  logic        l_req = 1'b0, l_we = 1'b0;
  logic [31:0] l_addr = '0, l_wdata = '0;
  logic        c_ack, l_ack;
  logic [31:0] c_rdata, l_rdata;
  logic        m_read, m_write, io_read, io_write;
  logic [31:0] addr_out, wdata_out;
  logic [31:0] mem_data = '0;
  logic [23:0] io_data = '0;
  logic        busy, grant_id;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic        port;
    logic [31:0] rdata;
  } exp_t;
  exp_t        sb[$];
  logic [31:0] c_model = '0;
  logic [31:0] l_model = '0;

  dmem_io_arbiter #(.IO_WAIT(IO_WAIT)) dut (
    .clock(clock), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ack(c_ack), .c_rdata(c_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_ack(l_ack), .l_rdata(l_rdata),
    .m_read(m_read), .m_write(m_write), .io_read(io_read), .io_write(io_write),
    .addr_out(addr_out), .wdata_out(wdata_out),
    .m_rdata(mem_data), .io_rdata(io_data),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic port, input logic we, input logic [31:0] rd);
    exp_t e;
    if (!we) begin
      if (port) l_model = rd;
      else      c_model = rd;
    end
    e.port  = port;
    e.rdata = port ? l_model : c_model;
    sb.push_back(e);
  endtask

  // Scoreboard: every ack is matched against the next expected completion.
  always @(negedge clock) begin
    if (rst_n) begin
      if ({m_read, m_write, io_read, io_write} != 4'b0000)
        chk("strobe_onehot", 32'($onehot({m_read, m_write, io_read, io_write})), 32'd1);
      if (c_ack || l_ack) begin
        chk("single_ack", 32'({c_ack, l_ack} != 2'b11), 32'd1);
        if (sb.size() == 0) begin
          chk("unexpected_ack", 32'({c_ack, l_ack}), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("ack_port", 32'(l_ack), 32'(e.port));
          chk("ack_rdata", l_ack ? l_rdata : c_rdata, e.rdata);
        end
      end
    end
  end

  task automatic wait_any_ack(output int at);
    at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (c_ack || l_ack) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) chk("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic single(input logic port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rd,
                        input int lat, input logic io);
    logic [3:0] exp_s;
    int         n;
    bit         done;
    done = 0;
    push_exp(port, we, rd);
    if (port) begin l_we = we; l_addr = addr; l_wdata = wdata; l_req = 1'b1; end
    else      begin c_we = we; c_addr = addr; c_wdata = wdata; c_req = 1'b1; end
    n = cyc;
    for (int d = 0; d < 40 && !done; d++) begin
      @(negedge clock);
      exp_s = 4'b0000;
      if (!io && d == 1) exp_s = we ? 4'b0100 : 4'b1000;
      if (io && d >= 1 && d <= IO_WAIT + 1) exp_s = we ? 4'b0001 : 4'b0010;
      chk("strobes", 32'({m_read, m_write, io_read, io_write}), 32'(exp_s));
      if (port ? l_ack : c_ack) begin
        done = 1;
        chk("latency", 32'(cyc - n), 32'(lat));
        chk("addr_out", addr_out, addr);
        chk("wdata_out", wdata_out, wdata);
      end
    end
    if (!done) chk("ack_timeout", 32'd0, 32'd1);
    @(posedge clock); #1;
    c_req = 1'b0;
    l_req = 1'b0;
  endtask

  initial begin
    int t0, t1, prev;

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_strobes", 32'({m_read, m_write, io_read, io_write}), 32'd0);
    chk("rst_busy_grant_ack", 32'({busy, grant_id, c_ack, l_ack}), 32'd0);
    chk("rst_addr_out", addr_out, 32'd0);
    chk("rst_c_rdata", c_rdata, 32'd0);
    @(posedge clock); #1;
    rst_n = 1'b1;

    mem_data = 32'hDEADBEEF;
    single(1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEADBEEF, 3, 1'b0);
    single(1'b1, 1'b1, 32'hFFFF_FC60, 32'h0012_3456, 32'h0, 3 + IO_WAIT, 1'b1);
    io_data = 24'hABCDEF;
    single(1'b0, 1'b0, 32'hFFFF_FC70, 32'h0, 32'h00AB_CDEF, 3 + IO_WAIT, 1'b1);
    single(1'b0, 1'b1, 32'h0000_0200, 32'h1122_3344, 32'h0, 3, 1'b0);
    mem_data = 32'hCAFE_F00D;
    single(1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, 3, 1'b0);
    mem_data = 32'h7777_1234;
    single(1'b0, 1'b0, 32'hFFFF_FBFC, 32'h0, 32'h7777_1234, 3, 1'b0);

    // Loader arrives while the CPU access is in flight.
    mem_data = 32'h5555_AAAA;
    push_exp(1'b0, 1'b0, 32'h5555_AAAA);
    push_exp(1'b1, 1'b1, 32'h0);
    c_addr = 32'h0000_0080; c_we = 1'b0; c_req = 1'b1;
    @(posedge clock); #1;
    l_addr = 32'h0000_0084; l_we = 1'b1; l_wdata = 32'h0BEE_F00D; l_req = 1'b1;
    wait_any_ack(t0);
    @(posedge clock); #1;
    c_req = 1'b0;
    wait_any_ack(t1);
    chk("ldr_after_cpu_gap", 32'(t1 - t0), 32'd4);
    @(posedge clock); #1;
    l_req = 1'b0;
    @(posedge clock); #1;

    // Both requesters held high across four grants.
    mem_data = 32'h0BAD_C0DE;
    c_addr = 32'h0000_0100; c_we = 1'b0;
    l_addr = 32'h0000_0104; l_we = 1'b1; l_wdata = 32'h1234_5678;
    for (int k = 0; k < 4; k++) begin
`ifdef DMEM_IO_ARB_RR_EN
      push_exp(k[0], k[0], 32'h0BAD_C0DE);
`else
      push_exp(1'b0, 1'b0, 32'h0BAD_C0DE);
`endif
    end
    c_req = 1'b1; l_req = 1'b1;
    prev = -1;
    for (int k = 0; k < 4; k++) begin
      wait_any_ack(t0);
      if (prev >= 0) chk("tie_spacing", 32'(t0 - prev), 32'd4);
      prev = t0;
    end
    @(posedge clock); #1;
    c_req = 1'b0; l_req = 1'b0;
    @(posedge clock); #1;

    // Reset in the middle of an IO strobe.
    c_addr = 32'hFFFF_FC70; c_we = 1'b0; c_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (io_read) break;
    end
    chk("io_read_seen", 32'(io_read), 32'd1);
    #2;
    rst_n = 1'b0;
    c_req = 1'b0;
    #1;
    chk("async_io_drop", 32'({io_read, io_write, busy}), 32'd0);
    c_model = '0;
    l_model = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_rdata", c_rdata | l_rdata, 32'd0);
    chk("rst_no_ack", 32'({c_ack, l_ack}), 32'd0);
    rst_n = 1'b1;

    mem_data = 32'h0F0F_0F0F;
    push_exp(1'b0, 1'b0, 32'h0F0F_0F0F);
    c_addr = 32'h0000_0020; c_we = 1'b0;
    l_addr = 32'h0000_0024; l_we = 1'b0;
    c_req = 1'b1; l_req = 1'b1;
    wait_any_ack(t0);
    chk("first_tie_cpu", 32'({c_ack, l_ack}), 32'b10);
    @(posedge clock); #1;
    c_req = 1'b0; l_req = 1'b0;
    repeat (3) @(posedge clock);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
